// File: rtl/conv1d_pool_stream.sv
// Streaming Conv1D -> optional ReLU -> MaxPool stage with valid/ready on input and output.
// Build option CONV1D_POOL_SAT_EN: saturate the per-channel result instead of two's-complement wrap.
module conv1d_pool_stream #(
  parameter int IN_LEN = 784,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 4,
  parameter int KERNEL = 5,
  parameter int POOL   = 4,
  parameter int BITS   = 31,
  parameter int FRAC   = 16,
  localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int IDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   act_en,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BITS:0]                          in_data,
  input  logic [OUT_CH*IN_CH*KERNEL*(BITS+1)-1:0] weights,
  input  logic [OUT_CH*(BITS+1)-1:0]             bias,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BITS:0]                          out_data,
  output logic [CH_W-1:0]                        out_ch,
  output logic [IDX_W-1:0]                       out_idx,
  output logic                                   busy,
  output logic                                   frame_done
);

  localparam int W     = BITS + 1;
  localparam int AW    = 2 * W;
  localparam int NW    = OUT_CH * IN_CH * KERNEL;
  localparam int POS_W = $clog2(IN_LEN + 1);
  localparam int C_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int K_W   = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int P_W   = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int WI_W  = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {IDLE, FILL, MAC, FIN, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic                act_q;
  logic [POS_W-1:0]    pos;
  logic [C_W-1:0]      c_in, c_cnt;
  logic [K_W-1:0]      k_cnt;
  logic [CH_W-1:0]     o_cnt;
  logic [P_W-1:0]      pc;
  logic [IDX_W-1:0]    grp;
  logic signed [W-1:0] stage [IN_CH];
  logic signed [W-1:0] win [KERNEL][IN_CH];
  logic signed [W-1:0] mx [OUT_CH];
  logic signed [AW-1:0] acc;

  logic signed [W-1:0] w_arr [NW];
  logic signed [W-1:0] b_arr [OUT_CH];

  always_comb begin
    for (int i = 0; i < NW; i++) w_arr[i] = weights[i*W +: W];
    for (int i = 0; i < OUT_CH; i++) b_arr[i] = bias[i*W +: W];
  end

  function automatic logic signed [W-1:0] max_init(input logic relu);
    return relu ? '0 : {1'b1, {BITS{1'b0}}};
  endfunction

  logic last_beat, last_tap, last_ch, last_pool, frame_in;
  assign last_beat = in_valid && (c_in == C_W'(IN_CH - 1));
  assign last_tap  = (k_cnt == K_W'(KERNEL - 1)) && (c_cnt == C_W'(IN_CH - 1));
  assign last_ch   = (o_cnt == CH_W'(OUT_CH - 1));
  assign last_pool = (pc == P_W'(POOL - 1));
  assign frame_in  = (pos == POS_W'(IN_LEN));

  logic [WI_W-1:0]      w_idx;
  logic signed [W-1:0]  tap_x, tap_w, red;
  logic signed [AW-1:0] prod, sum, act;

  assign w_idx = WI_W'((int'(o_cnt) * IN_CH + int'(c_cnt)) * KERNEL + int'(k_cnt));
  assign tap_x = win[k_cnt][c_cnt];
  assign tap_w = w_arr[w_idx];
  assign prod  = $signed({{W{tap_x[W-1]}}, tap_x}) * $signed({{W{tap_w[W-1]}}, tap_w});
  assign sum   = acc + $signed({{W{b_arr[o_cnt][W-1]}}, b_arr[o_cnt]});
  assign act   = (act_q && sum[AW-1]) ? '0 : sum;

`ifdef CONV1D_POOL_SAT_EN
  // In range exactly when every bit above BITS matches the sign.
  always_comb begin
    if (act[AW-1:BITS] == '0 || act[AW-1:BITS] == '1) red = W'(act);
    else red = act[AW-1] ? {1'b1, {BITS{1'b0}}} : {1'b0, {BITS{1'b1}}};
  end
`else
  assign red = W'(act);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_ch     = '0;
    out_idx    = '0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (last_beat && pos >= POS_W'(KERNEL - 1)) state_nxt = MAC;
      end
      MAC: if (last_tap) state_nxt = FIN;
      FIN: begin
        if (!last_ch)       state_nxt = MAC;
        else if (last_pool) state_nxt = EMIT;
        else if (frame_in)  state_nxt = DONE;
        else                state_nxt = FILL;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = mx[o_cnt];
        out_ch    = o_cnt;
        out_idx   = grp;
        if (out_ready && last_ch) state_nxt = frame_in ? DONE : FILL;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      pos   <= '0;
      c_in  <= '0;
      c_cnt <= '0;
      k_cnt <= '0;
      o_cnt <= '0;
      pc    <= '0;
      grp   <= '0;
      acc   <= '0;
      for (int c = 0; c < IN_CH; c++) stage[c] <= '0;
      for (int k = 0; k < KERNEL; k++)
        for (int c = 0; c < IN_CH; c++) win[k][c] <= '0;
      for (int o = 0; o < OUT_CH; o++) mx[o] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          act_q <= act_en;
          pos   <= '0;
          c_in  <= '0;
          c_cnt <= '0;
          k_cnt <= '0;
          o_cnt <= '0;
          pc    <= '0;
          grp   <= '0;
          acc   <= '0;
          for (int o = 0; o < OUT_CH; o++) mx[o] <= max_init(act_en);
        end
        FILL: if (in_valid) begin
          stage[c_in] <= in_data;
          if (last_beat) begin
            // Whole position gathered: shift window, oldest position at index 0.
            c_in <= '0;
            pos  <= pos + POS_W'(1);
            for (int k = 0; k < KERNEL - 1; k++) win[k] <= win[k+1];
            for (int c = 0; c < IN_CH; c++)
              win[KERNEL-1][c] <= (c == IN_CH - 1) ? in_data : stage[c];
          end else begin
            c_in <= c_in + C_W'(1);
          end
        end
        MAC: begin
          acc <= acc + (prod >>> FRAC);
          if (k_cnt == K_W'(KERNEL - 1)) begin
            k_cnt <= '0;
            c_cnt <= last_tap ? '0 : c_cnt + C_W'(1);
          end else begin
            k_cnt <= k_cnt + K_W'(1);
          end
        end
        FIN: begin
          acc <= '0;
          if (red > mx[o_cnt]) mx[o_cnt] <= red;
          if (last_ch) begin
            o_cnt <= '0;
            pc    <= last_pool ? '0 : pc + P_W'(1);
          end else begin
            o_cnt <= o_cnt + CH_W'(1);
          end
        end
        EMIT: if (out_ready) begin
          if (last_ch) begin
            o_cnt <= '0;
            grp   <= grp + IDX_W'(1);
            for (int o = 0; o < OUT_CH; o++) mx[o] <= max_init(act_q);
          end else begin
            o_cnt <= o_cnt + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_pool_stream.sv
// Directed bench: single-channel instance (IN_LEN=8) and two-channel instance (IN_LEN=9) sharing one clock.
`timescale 1ns/1ps
module tb_conv1d_pool_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IN_LEN=8, IN_CH=1, OUT_CH=1, KERNEL=3, POOL=2
  logic        a_start = 0, a_act = 0, a_iv = 0, a_or = 0;
  logic        a_ir, a_ov, a_busy, a_done;
  logic [31:0] a_id = '0, a_b = '0, a_od;
  logic [95:0] a_w = '0;
  logic [0:0]  a_och;
  logic [2:0]  a_oidx;

  conv1d_pool_stream #(.IN_LEN(8), .IN_CH(1), .OUT_CH(1), .KERNEL(3), .POOL(2), .BITS(31), .FRAC(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .act_en(a_act),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .weights(a_w), .bias(a_b),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_ch(a_och), .out_idx(a_oidx),
    .busy(a_busy), .frame_done(a_done));

  // Instance C: IN_LEN=9, IN_CH=2, OUT_CH=2, KERNEL=3, POOL=2
  logic         c_start = 0, c_act = 0, c_iv = 0, c_or = 0;
  logic         c_ir, c_ov, c_busy, c_done;
  logic [31:0]  c_id = '0, c_od;
  logic [63:0]  c_b = '0;
  logic [383:0] c_w = '0;
  logic [0:0]   c_och;
  logic [3:0]   c_oidx;

  conv1d_pool_stream #(.IN_LEN(9), .IN_CH(2), .OUT_CH(2), .KERNEL(3), .POOL(2), .BITS(31), .FRAC(16)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .act_en(c_act),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .weights(c_w), .bias(c_b),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_ch(c_och), .out_idx(c_oidx),
    .busy(c_busy), .frame_done(c_done));

  function automatic logic [31:0] fx(input int v);
    return 32'(v <<< 16);
  endfunction

  logic [31:0] a_vec [8];
  logic [31:0] c_vec [18];
  logic [31:0] got_d [8];
  int          got_ch [8];
  int          got_idx [8];
  logic [31:0] exp_d [8];
  int          got_n, beats, done_n, last_acc, done_cyc;

  // Runs one frame on instance A with out_ready held high.
  task automatic run_a(input logic act);
    int cyc;
    for (int i = 0; i < 8; i++) got_d[i] = 'x;
    @(negedge clk); a_act = act; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; a_or = 1'b1;
    got_n = 0; beats = 0; done_n = 0; last_acc = -1; done_cyc = -1; cyc = 0;
    while (done_n == 0 && cyc < 200) begin
      a_iv = (beats < 8);
      a_id = (beats < 8) ? a_vec[beats] : '0;
      if (a_iv && a_ir) beats++;
      if (a_ov && a_or) begin
        if (got_n < 8) begin got_d[got_n] = a_od; got_idx[got_n] = int'(a_oidx); end
        got_n++; last_acc = cyc;
      end
      if (a_done) begin done_n++; done_cyc = cyc; end
      @(negedge clk); cyc++;
    end
    a_iv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ov, a_ir, a_busy, a_done, a_od, a_oidx} !== '0) begin
      errors++; $display("FAIL reset_a got=%h want=0", {a_ov, a_ir, a_busy, a_done, a_od, a_oidx});
    end
    checks++;
    if ({c_ov, c_ir, c_busy, c_done, c_od, c_och, c_oidx} !== '0) begin
      errors++; $display("FAIL reset_c got=%h want=0", {c_ov, c_ir, c_busy, c_done, c_od, c_och, c_oidx});
    end
    rst = 1'b0;
  endtask

  task automatic test_relu_ramp();
    for (int i = 0; i < 8; i++) a_vec[i] = fx(i + 1);
    a_w = {3{fx(1)}}; a_b = '0;
    exp_d[0] = 32'h0009_0000; exp_d[1] = 32'h000F_0000; exp_d[2] = 32'h0015_0000;
    run_a(1'b1);
    checks++;
    if (done_n !== 1 || got_n !== 3 || beats !== 8) begin
      errors++; $display("FAIL ramp_counts done=%0d outs=%0d beats=%0d want 1/3/8", done_n, got_n, beats);
    end
    checks++;
    if (done_cyc !== last_acc + 1) begin
      errors++; $display("FAIL ramp_done_timing done_cyc=%0d want=%0d", done_cyc, last_acc + 1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_idx[i] !== i) begin
        errors++; $display("FAIL ramp_out%0d data=%h idx=%0d want data=%h idx=%0d", i, got_d[i], got_idx[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_negative_weights();
    a_w = {3{fx(-1)}}; a_b = '0;
    run_a(1'b1);
    checks++;
    if (got_n !== 3) begin errors++; $display("FAIL neg_relu_count got=%0d want=3", got_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== 32'h0) begin errors++; $display("FAIL neg_relu_out%0d got=%h want=00000000", i, got_d[i]); end
    end
    exp_d[0] = 32'hFFFA_0000; exp_d[1] = 32'hFFF4_0000; exp_d[2] = 32'hFFEE_0000;
    run_a(1'b0);
    checks++;
    if (got_n !== 3 || done_n !== 1) begin errors++; $display("FAIL neg_lin_counts outs=%0d done=%0d want 3/1", got_n, done_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_idx[i] !== i) begin
        errors++; $display("FAIL neg_lin_out%0d data=%h idx=%0d want data=%h idx=%0d", i, got_d[i], got_idx[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_bias();
    a_w = {3{fx(1)}}; a_b = 32'h0000_8000;
    exp_d[0] = 32'h0009_8000; exp_d[1] = 32'h000F_8000; exp_d[2] = 32'h0015_8000;
    run_a(1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL bias_out%0d got=%h want=%h", i, got_d[i], exp_d[i]); end
    end
    a_b = '0;
  endtask

  task automatic test_saturation();
    logic [31:0] e;
`ifdef CONV1D_POOL_SAT_EN
    e = 32'h7FFF_FFFF;
`else
    e = 32'h7FFD_0000;
`endif
    for (int i = 0; i < 8; i++) a_vec[i] = 32'h7FFF_0000;
    a_w = {3{fx(1)}};
    run_a(1'b1);
    checks++;
    if (got_n !== 3) begin errors++; $display("FAIL sat_count got=%0d want=3", got_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== e) begin errors++; $display("FAIL sat_out%0d got=%h want=%h", i, got_d[i], e); end
    end
    for (int i = 0; i < 8; i++) a_vec[i] = fx(i + 1);
  endtask

  task automatic test_reset_mid_mac();
    int dn;
    a_w = {3{fx(1)}}; a_b = '0;
    @(negedge clk); a_act = 1'b1; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin a_iv = 1'b1; a_id = a_vec[i]; @(negedge clk); end
    a_iv = 1'b0;
    checks++;
    if (a_ir !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL midmac_state in_ready=%b busy=%b want 0/1", a_ir, a_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ov, a_ir, a_busy, a_done, a_od} !== '0) begin
      errors++; $display("FAIL midmac_reset got=%h want=0", {a_ov, a_ir, a_busy, a_done, a_od});
    end
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (12) begin @(negedge clk); if (a_done || a_busy) dn++; end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midmac_quiet done_or_busy_cycles=%0d want=0", dn); end
    run_a(1'b1);
    checks++;
    if (got_n !== 3 || got_d[0] !== 32'h0009_0000 || got_d[2] !== 32'h0015_0000) begin
      errors++; $display("FAIL midmac_rerun outs=%0d d0=%h d2=%h want 3/00090000/00150000", got_n, got_d[0], got_d[2]);
    end
  endtask

  task automatic test_multi_channel_stall();
    int cyc, stall_left;
    logic started;
    logic [36:0] hold;
    int          exp_c [6];
    int          exp_i [6];
    for (int p = 0; p < 9; p++) begin c_vec[2*p] = fx(p + 1); c_vec[2*p+1] = fx(4 * (p + 1)); end
    for (int k = 0; k < 3; k++) begin
      c_w[k*32 +: 32]       = fx(1);
      c_w[(3+k)*32 +: 32]   = fx(0);
      c_w[(6+k)*32 +: 32]   = fx(-1);
      c_w[(9+k)*32 +: 32]   = fx(1);
    end
    c_b = {fx(1), fx(0)};
    exp_d[0] = 32'h0009_0000; exp_d[1] = 32'h001C_0000; exp_d[2] = 32'h000F_0000;
    exp_d[3] = 32'h002E_0000; exp_d[4] = 32'h0015_0000; exp_d[5] = 32'h0040_0000;
    for (int i = 0; i < 6; i++) begin exp_c[i] = i % 2; exp_i[i] = i / 2; got_d[i] = 'x; end
    @(negedge clk); c_act = 1'b1; c_start = 1'b1;
    @(negedge clk);
    got_n = 0; beats = 0; done_n = 0; cyc = 0; stall_left = 5; started = 1'b0; hold = '0;
    while (done_n == 0 && cyc < 500) begin
      c_start = (cyc == 3);
      c_iv = (beats < 18);
      c_id = (beats < 18) ? c_vec[beats] : '0;
      if (c_ov && !started) begin started = 1'b1; hold = {c_od, c_och, c_oidx}; end
      c_or = !(started && stall_left > 0);
      if (!c_or) begin
        checks++;
        if ({c_ov, c_ir, c_od, c_och, c_oidx} !== {1'b1, 1'b0, hold}) begin
          errors++; $display("FAIL stall_hold valid=%b ready_in=%b out=%h want 1/0/%h", c_ov, c_ir, {c_od, c_och, c_oidx}, hold);
        end
        stall_left--;
      end
      if (c_iv && c_ir) beats++;
      if (c_ov && c_or) begin
        if (got_n < 8) begin got_d[got_n] = c_od; got_ch[got_n] = int'(c_och); got_idx[got_n] = int'(c_oidx); end
        got_n++;
      end
      if (c_done) done_n++;
      @(negedge clk); cyc++;
    end
    c_iv = 1'b0; c_start = 1'b0;
    checks++;
    if (done_n !== 1 || got_n !== 6 || beats !== 18 || stall_left !== 0) begin
      errors++; $display("FAIL mc_counts done=%0d outs=%0d beats=%0d stall_left=%0d want 1/6/18/0", done_n, got_n, beats, stall_left);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_ch[i] !== exp_c[i] || got_idx[i] !== exp_i[i]) begin
        errors++; $display("FAIL mc_out%0d data=%h ch=%0d idx=%0d want data=%h ch=%0d idx=%0d",
                           i, got_d[i], got_ch[i], got_idx[i], exp_d[i], exp_c[i], exp_i[i]);
      end
    end
    checks++;
    if (c_done !== 1'b0 || c_busy !== 1'b0) begin
      errors++; $display("FAIL mc_after_done frame_done=%b busy=%b want 0/0", c_done, c_busy);
    end
  endtask

  initial begin
    test_reset();
    test_relu_ramp();
    test_negative_weights();
    test_bias();
    test_saturation();
    test_reset_mid_mac();
    test_multi_channel_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_pool_stream.md
Name: conv1d_pool_stream

Overview:
- Streaming successor to the array-based conv/pool chain: one fused Conv1D → optional ReLU → MaxPool stage with valid/ready handshakes on both sides.
- Replaces whole-frame flat buses and done-as-reset sequencing.
- Generalised in channel count, kernel, pool size and data width.
- Stages can be cascaded directly, so downstream consumes results without holding full feature maps.

Parameters:
IN_LEN, 784, input positions per frame
IN_CH, 1, input channels (channel-interleaved beats)
OUT_CH, 4, output channels (filters)
KERNEL, 5, taps per channel
POOL, 4, max-pool window (stride = POOL)
BITS, 31, data MSB index; words are BITS+1 bits, Q(BITS+1-FRAC).FRAC
FRAC, 16, fractional bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse: begin frame (sampled in IDLE only)
act_en  in  1  1 = ReLU, 0 = linear; sampled at start, held for frame
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  BITS+1  signed sample; order pos0 ch0..chIN_CH-1, pos1 ...
weights  in  OUT_CH*IN_CH*KERNEL x (BITS+1)  flat, index (o*IN_CH+c)*KERNEL+k
bias  in  OUT_CH x (BITS+1)  signed per filter
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accept
out_data  out  BITS+1  pooled signed result
out_ch  out  clog2(OUT_CH)  channel tag of out_data
out_idx  out  clog2(IN_LEN)  pooled position tag
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last pooled output accepted

Behaviour:
- Reset: all outputs 0, FSM IDLE, window/counters/pool maxima cleared. Reset mid-frame aborts; no frame_done.
- FSM: IDLE -start-> FILL; FILL -position complete & pos>=KERNEL-1-> MAC; MAC -IN_CH*KERNEL taps-> FIN; FIN -more channels-> MAC, else (pool group complete ? EMIT : FILL); EMIT -OUT_CH beats accepted-> (last group ? DONE : FILL); DONE -1 cycle-> IDLE.
- in_ready = 1 only in FILL; one beat per cycle.
- Window is a KERNEL x IN_CH shift register, shifted once per completed position.
- Conv output count = IN_LEN-KERNEL+1. Pooled count = floor(that/POOL). Trailing partial group is computed but never emitted; frame ends at last full group. Input beats for the trailing positions are still consumed (exactly IN_LEN*IN_CH accepted per frame).
- MAC: one multiply per cycle, 2(BITS+1)-bit product arithmetic-shifted right FRAC, summed into 2(BITS+1)-bit accumulator.
- FIN (1 cycle): add bias, apply act_en, reduce to BITS+1 bits, update running max for that channel.
- Running max: initialised per group to 0 if act_en, else most-negative value. Signed compare.
- Per position latency: OUT_CH*(IN_CH*KERNEL+1) cycles.
- EMIT: channels 0..OUT_CH-1 in order. out_data/out_ch/out_idx stable while out_valid & !out_ready. out_valid drops the cycle after the last accept.
- busy = 1 from cycle after start through DONE.
- start while busy: ignored.
- weights/bias must be stable while busy.

Optional Feature:
CONV1D_POOL_SAT_EN
- Defined: FIN reduction saturates to [-2^BITS, 2^BITS-1].
- Undefined: FIN reduction keeps the low BITS+1 bits (two's-complement wrap, matches existing layers).

Test Plan:
- IN_CH=1, OUT_CH=1, KERNEL=3, POOL=2, IN_LEN=8; weights 0x00010000; bias 0; in 1.0..8.0; act_en=1 -> conv 6,9,12,15,18,21; outputs 0x00090000, 0x000F0000, 0x00150000, out_idx 0,1,2, then frame_done.
- Same setup, weights -1.0 -> act_en=1: three outputs 0; act_en=0: 0xFFFA0000, 0xFFF40000, 0xFFEE0000.
- IN_LEN=9, same setup -> 7 conv outputs, 3 pooled outputs, 9 beats accepted, frame_done after 3rd accept.
- Inputs 0x7FFF0000 x3, weights 1.0 -> SAT_EN: 0x7FFFFFFF; without: low 32 bits of 0x17FFD0000 = 0x7FFD0000.
- IN_CH=2, OUT_CH=2, out_ready low 5 cycles during EMIT -> out_valid held, data/tags stable, in_ready 0; resumes on ready.
- rst asserted mid-MAC -> outputs 0 next edge, busy 0, no frame_done; new start yields correct first frame.
